muldiv_sequencer: RTL and testbench

Multi-cycle multiply/divide controller that implements the ALU control codes 1100–1111 (unsigned multiply, unsigned divide, signed multiply, signed divide). These operations cannot complete in the single-cycle combinational ALU. The block latches rs/rt on a start handshake and runs a radix-2 shift-add / restoring-divide sequence over WIDTH iterations. It writes the result into HI/LO registers for the MFHI/MFLO path and stalls the pipeline through `busy`.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        RUN   = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    // ALU control[1:0] when control[3:2] = 2'b11
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial-subtract for divide.
// acc holds the partial product high half / partial remainder; quo holds multiplier / dividend-quotient.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc} + (quo[0] ? {1'b0, m} : '0);
        shifted = {acc, quo[WIDTH-1]};
        // remainder < divisor, so the difference always fits back into WIDTH bits
        diff    = shifted[WIDTH-1:0] - m;
        fits    = (shifted >= {1'b0, m});
        if (is_div) begin
            acc_next = fits ? diff : shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], fits};
        end else begin
            acc_next = sum[WIDTH:1];
            quo_next = {sum[0], quo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide controller feeding HI/LO; stalls the pipeline through busy.
// Define MULDIV_SIGNED_EN to make op 10/11 signed; otherwise op[1] is ignored.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] acc_reg, quo_reg, m_reg;
    logic             is_div_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             dz_reg;

    logic             accept;
    logic             div_zero;
    logic [WIDTH-1:0] step_acc, step_quo;
    logic [WIDTH-1:0] abs_quo, abs_m;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    assign accept   = (state_reg == IDLE) && start && !kill;
    assign div_zero = is_div_reg && (m_reg == '0);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_reg),
        .acc      (acc_reg),
        .quo      (quo_reg),
        .m        (m_reg),
        .acc_next (step_acc),
        .quo_next (step_quo)
    );

`ifdef MULDIV_SIGNED_EN
    logic signed_reg, neg_q_reg, neg_r_reg;
    logic neg_a, neg_b;
    logic [2*WIDTH-1:0] prod;

    assign neg_a = signed_reg && quo_reg[WIDTH-1];
    assign neg_b = signed_reg && m_reg[WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            signed_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else if (accept) begin
            signed_reg <= op[1];
        end else if (state_reg == PREP) begin
            neg_q_reg <= neg_a ^ neg_b;
            neg_r_reg <= neg_a;
        end
    end

    always_comb begin
        abs_quo = neg_a ? -quo_reg : quo_reg;
        abs_m   = neg_b ? -m_reg : m_reg;
        prod    = {acc_reg, quo_reg};
        if (neg_q_reg)
            prod = -prod;
        if (is_div_reg) begin
            fix_hi = neg_r_reg ? -acc_reg : acc_reg;
            fix_lo = neg_q_reg ? -quo_reg : quo_reg;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end
`else
    logic unused_op_bit;
    assign unused_op_bit = op[1];
    assign abs_quo = quo_reg;
    assign abs_m   = m_reg;
    assign fix_hi  = acc_reg;
    assign fix_lo  = quo_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = div_zero ? DONE : RUN;
            RUN:     if (cnt_reg == LAST) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // a flush abandons the operation wherever it is, and blocks a start in IDLE
        if (kill)
            state_next = IDLE;
    end

    always_comb begin
        busy = (state_reg != IDLE);
        done = (state_reg == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            acc_reg    <= '0;
            quo_reg    <= '0;
            m_reg      <= '0;
            is_div_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dz_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (accept) begin
                    quo_reg    <= in1;
                    m_reg      <= in2;
                    is_div_reg <= op[0];
                end
                PREP: begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                    quo_reg <= abs_quo;
                    m_reg   <= abs_m;
                end
                RUN: begin
                    acc_reg <= step_acc;
                    quo_reg <= step_quo;
                    cnt_reg <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
            // HI/LO/dz are written on the edge that enters DONE; quo_reg still holds the raw dividend in PREP
            if (!kill) begin
                if (state_reg == PREP && div_zero) begin
                    hi_reg <= quo_reg;
                    lo_reg <= '1;
                    dz_reg <= 1'b1;
                end else if (state_reg == FIXUP) begin
                    hi_reg <= fix_hi;
                    lo_reg <= fix_lo;
                    dz_reg <= 1'b0;
                end
            end
        end
    end

    assign hi = hi_reg;
    assign lo = lo_reg;
    assign dz = dz_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized and directed bench for muldiv_sequencer against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, kill;
    logic [1:0]   op;
    logic [W-1:0] in1, in2;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] last_hi, last_lo;
    logic         last_dz;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .kill  (kill),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic, truncating division, remainder follows dividend.
    function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el,
                                  output logic ed, output int lat);
        logic   sg;
        longint sa, sb, r;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        sa  = sg ? longint'($signed(a)) : longint'({32'b0, a});
        sb  = sg ? longint'($signed(b)) : longint'({32'b0, b});
        ed  = 1'b0;
        lat = W + 2;
        if (o[0] == 1'b0) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else if (b == '0) begin
            eh  = a;
            el  = '1;
            ed  = 1'b1;
            lat = 1;
        end else begin
            r  = sa / sb;
            el = 32'(r);
            r  = sa % sb;
            eh = 32'(r);
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at);
        logic [W-1:0] eh, el;
        logic         ed;
        int           lat, k;
        bit           got, busy_ok;
        model(o, a, b, eh, el, ed, lat);
        @(negedge clk);
        op = o; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op  = 2'($urandom);
        in1 = $urandom;
        in2 = $urandom;
        k = 0; got = 0; busy_ok = 1;
        while (!got && k < 100) begin
            @(posedge clk);
            k++;
            #1;
            start = (k == poke_at);
            if (!busy) busy_ok = 0;
            if (done) got = 1;
        end
        start = 1'b0;
        check("busy_during_op", 64'(busy_ok), 64'd1);
        check("latency", 64'(k), 64'(lat));
        check("hi", 64'(hi), 64'(eh));
        check("lo", 64'(lo), 64'(el));
        check("dz", 64'(dz), 64'(ed));
        $display("op=%0d in1=%h in2=%h -> hi=%h lo=%h dz=%b cycles=%0d", o, a, b, hi, lo, dz, k);
        @(posedge clk);
        #1;
        check("done_single_pulse", 64'(done), 64'd0);
        check("busy_after_done", 64'(busy), 64'd0);
        check("hi_held", 64'(hi), 64'(eh));
        last_hi = eh;
        last_lo = el;
        last_dz = ed;
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        bit           saw_done;

        reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_dz", 64'(dz), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MUL,  32'hFFFF_FFFD, 32'd5, -1);
        run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, -1);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, -1);
        run_op(OP_DIVU, 32'd5, 32'd9, -1);
        run_op(OP_DIVU, 32'd100, 32'd0, -1);
        run_op(OP_MULU, 32'h0000_1234, 32'h0000_5678, 5);
        run_op(OP_DIV,  32'hFFFF_FF00, 32'd0, -1);

        // kill at cycle 10 of a divide
        @(negedge clk);
        op = OP_DIVU; in1 = 32'd1000; in2 = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'd0);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1;
        end
        check("kill_no_done", 64'(saw_done), 64'd0);
        check("kill_hilo_kept", {hi, lo}, {last_hi, last_lo});
        check("kill_dz_kept", 64'(dz), 64'(last_dz));
        $display("kill during divide -> busy=%b hi=%h lo=%h", busy, hi, lo);

        // kill together with start in IDLE
        @(negedge clk);
        op = OP_MULU; in1 = 32'd3; in2 = 32'd4; start = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; kill = 1'b0;
        check("kill_start_idle", 64'(busy), 64'd0);
        $display("kill+start in idle -> busy=%b", busy);

        // reset at cycle 20 of a divide, after a divide-by-zero left dz set
        run_op(OP_DIVU, 32'd100, 32'd0, -1);
        @(negedge clk);
        op = OP_DIVU; in1 = 32'd12345; in2 = 32'd11; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hilo", {hi, lo}, 64'd0);
        check("midreset_dz", 64'(dz), 64'd0);
        $display("reset during divide -> busy=%b hi=%h lo=%h dz=%b", busy, hi, lo, dz);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = -32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, (i % 4 == 0) ? 5 : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
